game_sequencer: RTL



---
 rtl/game_sequencer_pkg.sv | 38 +++
 rtl/game_sequencer_if.sv | 35 +++
 rtl/game_sequencer_beat_counter.sv | 27 ++
 rtl/game_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/game_sequencer_pkg.sv
// Shared types and constants for the rhythm-game play controller.
// Package game_pkg: state/mode codes, difficulty divider limits and the
// diff_sel to divider-limit lookup.
package game_pkg;

    // State encoding doubles as the mode code driven to the datapath.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_PAUSE     = 3'd3,
        S_DRAIN     = 3'd4,
        S_DONE      = 3'd5,
        S_FAIL      = 3'd6
    } state_t;

    // Clock-divider limits for the four difficulty levels.
    localparam logic [22:0] DIFF_EASY   = 23'd5_000_000;
    localparam logic [22:0] DIFF_MED    = 23'd2_500_000;
    localparam logic [22:0] DIFF_HARD   = 23'd1_250_000;
    localparam logic [22:0] DIFF_EXPERT = 23'd625_000;

    // Each 64-bit note word scrolls for this many beats.
    localparam logic [7:0] WORD_BEATS = 8'd32;

    // Width of the shared beat counter (covers countdown, word and drain).
    localparam int CNT_W = 8;

    function automatic logic [22:0] diff_limit(input logic [1:0] sel);
        case (sel)
            2'd0:    return DIFF_EASY;
            2'd1:    return DIFF_MED;
            2'd2:    return DIFF_HARD;
            default: return DIFF_EXPERT;
        endcase
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Bundle of control, song-ROM and datapath signals around game_sequencer.
// All inputs are single-cycle strobes or levels already synchronous to clk:
// start_pulse, pause_pulse and beat_clk are each high for exactly one cycle
// per event and there is no back-pressure; rom_data answers rom_addr one
// cycle later.
interface game_sequencer_if #(
    parameter int ADDR_W = 6
);
    logic              start_pulse;
    logic              pause_pulse;
    logic [1:0]        diff_sel;
    logic              beat_clk;
    logic [7:0]        num_misses;
    logic [63:0]       rom_data;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       notes1;
    logic [31:0]       notes2;
    logic [2:0]        mode;
    logic [22:0]       diff;
    logic [2:0]        countdown;
    logic              song_done;
    logic              game_over;

    // Sequencer side.
    modport slave (
        input  start_pulse, pause_pulse, diff_sel, beat_clk, num_misses, rom_data,
        output rom_addr, notes1, notes2, mode, diff, countdown, song_done, game_over
    );

    // Environment side: buttons, ROM and datapath.
    modport master (
        output start_pulse, pause_pulse, diff_sel, beat_clk, num_misses, rom_data,
        input  rom_addr, notes1, notes2, mode, diff, countdown, song_done, game_over
    );
endinterface

// File: rtl/game_sequencer_beat_counter.sv
// Generic beat counter: synchronous clear, count enable, and a terminal
// flag that is high while the next enabled beat is the last of i_limit.
// On that terminal beat the count wraps to 0, ready for the next phase.
module game_sequencer_beat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_limit,
    output logic         o_tc
);
    logic [W-1:0] r_count;

    assign o_tc = (r_count == i_limit - W'(1));

    // Count enabled beats, wrapping at the terminal beat.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_en)
            r_count <= o_tc ? '0 : r_count + W'(1);
    end
endmodule

// File: rtl/game_sequencer.sv
// Rhythm-game play controller: idle -> countdown -> play -> drain -> done,
// with pause/resume, restart and optional miss-limit failure.
// Optional feature macro: GAME_SEQUENCER_MISS_FAIL_EN (miss-limit -> FAIL).
module game_sequencer
    import game_pkg::*;
#(
    parameter int          ADDR_W      = 6,
    parameter int          SONG_WORDS  = 8,
    parameter int          COUNT_BEATS = 4,
    parameter int          DRAIN_BEATS = 39,
    parameter logic [7:0]  MISS_LIMIT  = 8'h50
) (
    input  logic               clk,
    input  logic               n_rst,
    game_sequencer_if.slave    bus
);
    // One extra address bit so a song filling the whole ROM can still be
    // recognised as finished.
    localparam logic [ADDR_W:0] SONG_LEN = SONG_WORDS[ADDR_W:0];

    state_t          r_state;
    state_t          r_saved;
    logic [ADDR_W:0] r_addr;
    logic [31:0]     r_notes1;
    logic [31:0]     r_notes2;
    logic [22:0]     r_diff;
    logic [2:0]      r_countdown;
    logic            r_song_done;

    state_t          w_next;
    logic            w_restart;
    logic            w_abort;
    logic            w_pause_in;
    logic            w_fail;
    logic            w_cnt_clr;
    logic            w_cnt_en;
    logic            w_tc;
    logic            w_miss;
    logic [CNT_W-1:0] w_limit;

`ifdef GAME_SEQUENCER_MISS_FAIL_EN
    logic r_game_over;
    assign w_miss = ((r_state == S_PLAY) || (r_state == S_DRAIN)) &&
                    (bus.num_misses >= MISS_LIMIT);
    assign bus.game_over = r_game_over;
`else
    logic w_unused_misses;
    assign w_unused_misses = ^bus.num_misses;
    assign w_miss = 1'b0;
    assign bus.game_over = 1'b0;
`endif

    game_sequencer_beat_counter #(.W(CNT_W)) u_beats (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .i_limit (w_limit),
        .o_tc    (w_tc)
    );

    // Next-state and per-cycle event decode; start beats miss beats pause beats beat.
    always_comb begin
        w_next     = r_state;
        w_restart  = 1'b0;
        w_abort    = 1'b0;
        w_pause_in = 1'b0;
        w_fail     = 1'b0;
        w_cnt_en   = 1'b0;
        w_limit    = WORD_BEATS;
        if (r_state == S_COUNTDOWN)
            w_limit = CNT_W'(COUNT_BEATS);
        else if (r_state == S_DRAIN)
            w_limit = CNT_W'(DRAIN_BEATS);

        case (r_state)
            S_COUNTDOWN, S_PLAY, S_DRAIN: begin
                if (bus.start_pulse) begin
                    w_restart = 1'b1;
                end else if (w_miss) begin
                    w_fail = 1'b1;
                    w_next = S_FAIL;
                end else if (bus.pause_pulse) begin
                    w_pause_in = 1'b1;
                    w_next     = S_PAUSE;
                end else if (bus.beat_clk) begin
                    w_cnt_en = 1'b1;
                    if (w_tc) begin
                        if (r_state == S_COUNTDOWN)
                            w_next = S_PLAY;
                        else if (r_state == S_PLAY)
                            w_next = (r_addr < SONG_LEN) ? S_PLAY : S_DRAIN;
                        else
                            w_next = S_DONE;
                    end
                end
            end
            S_PAUSE: begin
                if (bus.start_pulse) begin
                    w_abort = 1'b1;
                    w_next  = S_IDLE;
                end else if (bus.pause_pulse) begin
                    w_next = r_saved;
                end
            end
            default: begin
                if (bus.start_pulse)
                    w_restart = 1'b1;
            end
        endcase

        if (w_restart)
            w_next = S_COUNTDOWN;
        w_cnt_clr = w_restart | w_abort;
    end

    // Registered FSM: state, ROM address, note words and status outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= S_IDLE;
            r_saved     <= S_IDLE;
            r_addr      <= '0;
            r_notes1    <= '0;
            r_notes2    <= '0;
            r_diff      <= DIFF_EASY;
            r_countdown <= '0;
            r_song_done <= 1'b0;
`ifdef GAME_SEQUENCER_MISS_FAIL_EN
            r_game_over <= 1'b0;
`endif
        end else begin
            r_state     <= w_next;
            r_song_done <= (w_next == S_DONE);
`ifdef GAME_SEQUENCER_MISS_FAIL_EN
            r_game_over <= (w_next == S_FAIL);
`endif
            if (w_pause_in)
                r_saved <= r_state;

            if (w_restart) begin
                r_diff      <= diff_limit(bus.diff_sel);
                r_addr      <= '0;
                r_countdown <= 3'(COUNT_BEATS);
                r_notes1    <= '0;
                r_notes2    <= '0;
            end else if (w_abort) begin
                r_countdown <= '0;
                r_notes1    <= '0;
                r_notes2    <= '0;
            end else if (w_fail) begin
                r_notes1 <= '0;
                r_notes2 <= '0;
            end else if (w_cnt_en) begin
                if (r_state == S_COUNTDOWN) begin
                    r_countdown <= r_countdown - 3'd1;
                    if (w_tc) begin
                        // Address 0 was issued on entry, so its word is waiting.
                        r_notes1 <= bus.rom_data[63:32];
                        r_notes2 <= bus.rom_data[31:0];
                        r_addr   <= (ADDR_W+1)'(1);
                    end
                end else if ((r_state == S_PLAY) && w_tc) begin
                    if (r_addr < SONG_LEN) begin
                        r_notes1 <= bus.rom_data[63:32];
                        r_notes2 <= bus.rom_data[31:0];
                        r_addr   <= r_addr + (ADDR_W+1)'(1);
                    end else begin
                        r_notes1 <= '0;
                        r_notes2 <= '0;
                    end
                end
            end
        end
    end

    assign bus.rom_addr  = r_addr[ADDR_W-1:0];
    assign bus.notes1    = r_notes1;
    assign bus.notes2    = r_notes2;
    assign bus.mode      = r_state;
    assign bus.diff      = r_diff;
    assign bus.countdown = r_countdown;
    assign bus.song_done = r_song_done;
endmodule
